xadac_resp_arb: RTL and testbench
=================================

# xadac_resp_arb

Round-robin response arbiter for the xadac execution stage. Merges the response channels of `NoUnits` functional units (vactv, vbias, vload, vmacc) onto the single response channel returned to the core. A grant is locked from the first cycle a unit's response is offered until that response handshakes, so the core never sees a payload change under `resp_valid`. An optional output register stage breaks the unit-to-core combinational path.

## Interface
- `NoUnits`, 4: number of unit response channels; ≥2.
- `IdWidth`, `xadac_pkg::IdWidth`: response ID width.
- `XlenWidth`, 32: scalar result width.
- `VecWidth`, `xadac_pkg::VecWidth`: vector result width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `unit_resp_valid`  in  NoUnits  per-unit response valid.
- `unit_resp_ready`  out  NoUnits  per-unit response ready; one-hot or zero.
- `unit_resp_id`  in  NoUnits×IdWidth  per-unit ID.
- `unit_resp_rd`  in  NoUnits×XlenWidth  per-unit scalar result.
- `unit_resp_vd`  in  NoUnits×VecWidth  per-unit vector result.
- `unit_resp_rd_write`  in  NoUnits  per-unit scalar writeback enable.
- `unit_resp_vd_write`  in  NoUnits  per-unit vector writeback enable.
- `resp_valid`  out  1  merged response valid.
- `resp_ready`  in  1  core ready.
- `resp_id`, `resp_rd`, `resp_vd`, `resp_rd_write`, `resp_vd_write`  out  IdWidth / XlenWidth / VecWidth / 1 / 1  merged payload.
- `resp_unit`  out  clog2(NoUnits)  index of the unit that sourced the current response (debug/perf).

## Operation
- State: `ptr_q` (round-robin priority start), `lock_q` (grant held), `grant_q` (locked index).
- Idle (`lock_q`=0): winner is the first valid unit scanning `ptr_q`, `ptr_q`+1, … mod `NoUnits`. No valid unit → no grant, all `unit_resp_ready`=0.
- Grant: payload muxed from the winner. `unit_resp_ready[w]` = downstream ready (`resp_ready`, or buffer-accept when registered).
- Offered but not accepted: `lock_q`←1, `grant_q`←w. While locked, arbitration is frozen, and valids from other units are ignored even if higher priority.
- Handshake on the granted unit: `lock_q`←0, `ptr_q`←w+1 (wraps at `NoUnits`-1→0). The next cycle re-arbitrates.
- Handshake in the first offered cycle: no lock is taken; `ptr_q` still advances.
- Units must hold valid and payload until ready. If a unit violates this while locked, it is an assertion error (simulation only); the RTL keeps the grant.
- `resp_unit` = granted index while `resp_valid`; otherwise 0.

## Timing
- Reset values: `resp_valid`=0, `unit_resp_ready`=0, all payload outputs 0, `resp_unit`=0, `ptr_q`=0, `lock_q`=0, `grant_q`=0.
- Without register: latency 0. Throughput is one response per cycle, and back-to-back responses can come from different units.
- With register: latency 1 cycle. One-entry buffer with `accept` = !full | `resp_ready`, giving full throughput with no bubble. The buffer fill happens in the same cycle as the unit handshake.
- Reset asserted mid-transfer: the lock and buffered response are discarded, and outputs return to their reset values asynchronously.

## Configuration
- `XADAC_RESP_ARB_REG_EN` defined: output register stage present, and the `resp_*` outputs come straight from flops.
- Not defined: `resp_*` outputs are combinational from the unit inputs, and `unit_resp_ready` is combinational from `resp_ready`.
- Arbitration and lock behaviour are identical in both builds.

## Structure
- `xadac_pkg` holds `IdT`, `XlenT`, `VectorT`, `IdWidth`, `VecWidth` and a `resp_t` struct (id, rd, vd, rd_write, vd_write), which is used for payload muxing and the buffer entry.
- Sub-module `xadac_rr_pick`: combinational. Takes a request vector and start pointer; outputs the one-hot grant, the index and an any-valid flag. It is reusable for a future request-side scheduler.

## Test plan
- Single unit: unit 2 valid with id=5, rd=0x1234, rd_write=1, `resp_ready`=1. Expect `resp_valid` in the same cycle (cycle +1 with REG_EN), `resp_unit`=2, and `ptr_q`→3.
- Fairness: all four units continuously valid, `resp_ready`=1, starting from reset. Expect grant order 0,1,2,3,0,1 with one response per cycle.
- Lock: unit 1 is valid and `resp_ready`=0 for 3 cycles while unit 0 raises valid in cycle 2. Expect unit 1 held with a stable payload and `unit_resp_ready`=0 for all units; then `resp_ready`=1 gives unit 1's handshake, followed by unit 2/3/0 order from `ptr_q`=2.
- Wrap: `ptr_q`=3 with units 3 and 0 valid. Expect unit 3 first, then `ptr_q`→0 and unit 0 next.
- Back-pressure with REG_EN: `resp_ready` toggles 1,0,1,0 with units 0 and 1 valid. Expect no lost or duplicated IDs and buffer-full stalls to match.
- Reset mid-lock: assert `rst` while unit 2 is locked. Expect `resp_valid`=0 immediately, and after release, arbitration restarts from unit 0.

Source files
------------

// File: rtl/xadac_pkg.sv
// Shared xadac types: ID/result widths and the response payload bundle.
package xadac_pkg;

   localparam int unsigned IdWidth   = 8;
   localparam int unsigned XlenWidth = 32;
   localparam int unsigned VecWidth  = 64;

   typedef logic [IdWidth-1:0]   IdT;
   typedef logic [XlenWidth-1:0] XlenT;
   typedef logic [VecWidth-1:0]  VectorT;

   typedef struct packed {
      IdT     id;
      XlenT   rd;
      VectorT vd;
      logic   rd_write;
      logic   vd_write;
   } resp_t;

endpackage

// File: rtl/xadac_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward, modulo N.
module xadac_rr_pick #(
   parameter  int unsigned N = 4,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);

   logic [W-1:0] k;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         k = W'((32'(ptr) + i) % N);
         if (!any && req[k]) begin
            any    = 1'b1;
            gnt[k] = 1'b1;
            idx    = k;
         end
      end
   end

endmodule

// File: rtl/xadac_resp_arb.sv
// Round-robin response arbiter merging unit responses onto the core response channel.
// Define XADAC_RESP_ARB_REG_EN to add a one-entry output register stage.
module xadac_resp_arb #(
   parameter  int unsigned NoUnits   = 4,
   parameter  int unsigned IdWidth   = xadac_pkg::IdWidth,
   parameter  int unsigned XlenWidth = 32,
   parameter  int unsigned VecWidth  = xadac_pkg::VecWidth,
   localparam int unsigned UnitW     = $clog2(NoUnits)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NoUnits-1:0]                 unit_resp_valid,
   output logic [NoUnits-1:0]                 unit_resp_ready,
   input  logic [NoUnits-1:0][IdWidth-1:0]    unit_resp_id,
   input  logic [NoUnits-1:0][XlenWidth-1:0]  unit_resp_rd,
   input  logic [NoUnits-1:0][VecWidth-1:0]   unit_resp_vd,
   input  logic [NoUnits-1:0]                 unit_resp_rd_write,
   input  logic [NoUnits-1:0]                 unit_resp_vd_write,
   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [IdWidth-1:0]                 resp_id,
   output logic [XlenWidth-1:0]               resp_rd,
   output logic [VecWidth-1:0]                resp_vd,
   output logic                               resp_rd_write,
   output logic                               resp_vd_write,
   output logic [UnitW-1:0]                   resp_unit
);
   import xadac_pkg::*;

   logic [UnitW-1:0]   ptr_q, ptr_d, grant_q, grant_d;
   logic               lock_q, lock_d;
   logic [NoUnits-1:0] pick_gnt, sel_oh;
   logic [UnitW-1:0]   pick_idx, sel_idx;
   logic               pick_any, sel_valid, accept, hs;
   resp_t              sel_resp, out_resp;
   logic               out_valid;
   logic [UnitW-1:0]   out_unit;

   xadac_rr_pick #(.N(NoUnits)) u_pick (
      .req (unit_resp_valid),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // While locked the picker result is ignored; the held grant keeps the payload stable.
   always_comb begin
      sel_idx = lock_q ? grant_q : pick_idx;
      sel_oh  = '0;
      if (lock_q) sel_oh[grant_q] = 1'b1;
      else        sel_oh = pick_gnt;
      sel_valid = (lock_q ? unit_resp_valid[grant_q] : pick_any) & ~rst;
      sel_resp.id       = unit_resp_id[sel_idx];
      sel_resp.rd       = unit_resp_rd[sel_idx];
      sel_resp.vd       = unit_resp_vd[sel_idx];
      sel_resp.rd_write = unit_resp_rd_write[sel_idx];
      sel_resp.vd_write = unit_resp_vd_write[sel_idx];
      hs              = sel_valid & accept;
      unit_resp_ready = hs ? sel_oh : '0;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      grant_d = grant_q;
      if (hs) begin
         lock_d = 1'b0;
         ptr_d  = (sel_idx == UnitW'(NoUnits - 1)) ? '0 : sel_idx + 1'b1;
      end else if (sel_valid && !lock_q) begin
         lock_d  = 1'b1;
         grant_d = sel_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         lock_q  <= 1'b0;
         grant_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
         grant_q <= grant_d;
      end
   end

`ifdef XADAC_RESP_ARB_REG_EN
   resp_t            buf_q, buf_d;
   logic             full_q, full_d;
   logic [UnitW-1:0] unit_q, unit_d;

   assign accept = ~full_q | resp_ready;

   always_comb begin
      buf_d  = buf_q;
      full_d = full_q;
      unit_d = unit_q;
      if (accept) begin
         full_d = sel_valid;
         buf_d  = sel_valid ? sel_resp : '0;
         unit_d = sel_valid ? sel_idx : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q  <= '0;
         full_q <= 1'b0;
         unit_q <= '0;
      end else begin
         buf_q  <= buf_d;
         full_q <= full_d;
         unit_q <= unit_d;
      end
   end

   assign out_valid = full_q;
   assign out_resp  = buf_q;
   assign out_unit  = unit_q;
`else
   assign accept    = resp_ready;
   assign out_valid = sel_valid;
   assign out_resp  = sel_valid ? sel_resp : '0;
   assign out_unit  = sel_valid ? sel_idx : '0;
`endif

   assign resp_valid    = out_valid;
   assign resp_id       = out_resp.id;
   assign resp_rd       = out_resp.rd;
   assign resp_vd       = out_resp.vd;
   assign resp_rd_write = out_resp.rd_write;
   assign resp_vd_write = out_resp.vd_write;
   assign resp_unit     = out_unit;

   a_locked_holds_valid: assert property (@(posedge clk) disable iff (rst)
      lock_q |-> unit_resp_valid[grant_q]);

endmodule

// File: tb/tb_xadac_resp_arb.sv
// Bench for xadac_resp_arb (default build): directed table, corner sequences, random vs. model.
module tb_xadac_resp_arb;
   localparam int N  = 4;
   localparam int IW = xadac_pkg::IdWidth;
   localparam int XW = 32;
   localparam int VW = xadac_pkg::VecWidth;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         uv;
   logic [N-1:0]         urdy;
   logic [N-1:0][IW-1:0] uid;
   logic [N-1:0][XW-1:0] urd;
   logic [N-1:0][VW-1:0] uvd;
   logic [N-1:0]         urdw, uvdw;
   logic                 rv, rr;
   logic [IW-1:0]        rid;
   logic [XW-1:0]        rrd;
   logic [VW-1:0]        rvd;
   logic                 rrdw, rvdw;
   logic [1:0]           runit;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   xadac_resp_arb dut (
      .clk(clk), .rst(rst),
      .unit_resp_valid(uv), .unit_resp_ready(urdy),
      .unit_resp_id(uid), .unit_resp_rd(urd), .unit_resp_vd(uvd),
      .unit_resp_rd_write(urdw), .unit_resp_vd_write(uvdw),
      .resp_valid(rv), .resp_ready(rr),
      .resp_id(rid), .resp_rd(rrd), .resp_vd(rvd),
      .resp_rd_write(rrdw), .resp_vd_write(rvdw),
      .resp_unit(runit)
   );

   typedef struct {
      logic [3:0] v;
      logic       r;
      logic       ev;
      int         eu;
      logic [3:0] erdy;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] fix_id(input int u);
      return IW'(8'h10 + u);
   endfunction

   function automatic logic [XW-1:0] fix_rd(input int u);
      return XW'(32'h1000 * (u + 1) + 32'h34);
   endfunction

   task automatic set_fixed_payloads();
      for (int u = 0; u < N; u++) begin
         uid[u]  = fix_id(u);
         urd[u]  = fix_rd(u);
         uvd[u]  = {32'(u), 32'hA5A5_0000 + 32'(u)};
         urdw[u] = 1'b1;
         uvdw[u] = (u % 2) == 1;
      end
   endtask

   task automatic check_out(input string tag, input logic ev, input int eu, input logic [3:0] erdy);
      chk($sformatf("%s.valid", tag), 64'(rv), 64'(ev));
      chk($sformatf("%s.unit", tag), 64'(runit), ev ? 64'(eu) : 64'd0);
      chk($sformatf("%s.ready", tag), 64'(urdy), 64'(erdy));
      chk($sformatf("%s.id", tag), 64'(rid), ev ? 64'(fix_id(eu)) : 64'd0);
      chk($sformatf("%s.rd", tag), 64'(rrd), ev ? 64'(fix_rd(eu)) : 64'd0);
   endtask

   // Apply inputs at the falling edge, sample 2 time units later, well clear of the rising edge.
   task automatic step(input string tag, input logic [3:0] v, input logic r,
                       input logic ev, input int eu, input logic [3:0] erdy);
      uv = v;
      rr = r;
      #2;
      check_out(tag, ev, eu, erdy);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      uv  = '0;
      rr  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reference model state for the random phase.
   int            m_ptr, m_owner;
   logic [N-1:0]  pend;

   initial begin
      rst = 1'b1;
      uv  = '0;
      rr  = 1'b0;
      set_fixed_payloads();

      // Reset state, including valid inputs held during reset.
      #2;
      check_out("reset_idle", 1'b0, 0, 4'b0000);
      uv = 4'b1111;
      rr = 1'b1;
      #1;
      check_out("reset_busy", 1'b0, 0, 4'b0000);
      @(negedge clk);
      rst = 1'b0;

      tbl[0]  = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000};
      tbl[1]  = '{4'b0100, 1'b1, 1'b1, 2, 4'b0100};
      tbl[2]  = '{4'b1001, 1'b1, 1'b1, 3, 4'b1000};
      tbl[3]  = '{4'b1001, 1'b1, 1'b1, 0, 4'b0001};
      tbl[4]  = '{4'b0011, 1'b0, 1'b1, 1, 4'b0000};
      tbl[5]  = '{4'b0011, 1'b0, 1'b1, 1, 4'b0000};
      tbl[6]  = '{4'b0011, 1'b1, 1'b1, 1, 4'b0010};
      tbl[7]  = '{4'b1101, 1'b1, 1'b1, 2, 4'b0100};
      tbl[8]  = '{4'b1001, 1'b1, 1'b1, 3, 4'b1000};
      tbl[9]  = '{4'b0001, 1'b1, 1'b1, 0, 4'b0001};
      tbl[10] = '{4'b1111, 1'b1, 1'b1, 1, 4'b0010};
      tbl[11] = '{4'b1111, 1'b0, 1'b1, 2, 4'b0000};
      tbl[12] = '{4'b0111, 1'b0, 1'b1, 2, 4'b0000};
      tbl[13] = '{4'b0111, 1'b1, 1'b1, 2, 4'b0100};
      tbl[14] = '{4'b0011, 1'b1, 1'b1, 0, 4'b0001};
      for (int i = 0; i < 15; i++)
         step($sformatf("tbl%0d", i), tbl[i].v, tbl[i].r, tbl[i].ev, tbl[i].eu, tbl[i].erdy);

      // Fairness from reset: all valid, always ready.
      do_reset();
      for (int i = 0; i < 6; i++)
         step($sformatf("fair%0d", i), 4'b1111, 1'b1, 1'b1, i % N, 4'(1 << (i % N)));

      // Lock: unit 1 stalled, unit 0 (higher priority from ptr 0) arrives mid-stall.
      do_reset();
      step("lock0", 4'b0010, 1'b0, 1'b1, 1, 4'b0000);
      step("lock1", 4'b0010, 1'b0, 1'b1, 1, 4'b0000);
      step("lock2", 4'b0011, 1'b0, 1'b1, 1, 4'b0000);
      step("lock3", 4'b0011, 1'b1, 1'b1, 1, 4'b0010);
      step("lock4", 4'b1111, 1'b1, 1'b1, 2, 4'b0100);
      step("lock5", 4'b1111, 1'b1, 1'b1, 3, 4'b1000);
      step("lock6", 4'b1111, 1'b1, 1'b1, 0, 4'b0001);

      // Reset while unit 2 holds the lock.
      do_reset();
      step("rml0", 4'b0100, 1'b0, 1'b1, 2, 4'b0000);
      uv = 4'b0101;
      #2;
      check_out("rml1", 1'b1, 2, 4'b0000);
      rst = 1'b1;
      #1;
      check_out("rml_async", 1'b0, 0, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      step("rml2", 4'b1111, 1'b1, 1'b1, 0, 4'b0001);

      // Random traffic against a transaction-level model.
      do_reset();
      m_ptr   = 0;
      m_owner = -1;
      pend    = '0;
      for (int c = 0; c < 400; c++) begin
         for (int u = 0; u < N; u++) begin
            if (!pend[u] && ($urandom % 3) == 0) begin
               pend[u] = 1'b1;
               uid[u]  = IW'($urandom);
               urd[u]  = $urandom;
               uvd[u]  = {$urandom, $urandom};
               urdw[u] = 1'($urandom);
               uvdw[u] = 1'($urandom);
            end
         end
         uv = pend;
         rr = ($urandom % 4) != 0;
         #2;
         if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
               if (m_owner < 0 && pend[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            end
         end
         chk($sformatf("rnd%0d.valid", c), 64'(rv), 64'(m_owner >= 0));
         chk($sformatf("rnd%0d.ready", c), 64'(urdy),
             (m_owner >= 0 && rr) ? 64'(1 << m_owner) : 64'd0);
         if (m_owner >= 0) begin
            chk($sformatf("rnd%0d.unit", c), 64'(runit), 64'(m_owner));
            chk($sformatf("rnd%0d.id", c), 64'(rid), 64'(uid[m_owner]));
            chk($sformatf("rnd%0d.rd", c), 64'(rrd), 64'(urd[m_owner]));
            chk($sformatf("rnd%0d.vd", c), 64'(rvd), 64'(uvd[m_owner]));
            chk($sformatf("rnd%0d.wr", c), 64'({rrdw, rvdw}), 64'({urdw[m_owner], uvdw[m_owner]}));
            if (rr) begin
               m_ptr   = (m_owner + 1) % N;
               m_owner = -1;
            end
         end
         pend = pend & ~urdy;
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
